// File: rtl/simd_job_sched.sv
// Round-robin job scheduler sharing one simd_array between two requesters.
// Handles MAC accumulator clear, response filtering and a drain watchdog.
module simd_job_sched #(
  parameter int UNIT_SIZE = 32,
  parameter int WIDTH     = 5,
  parameter int TIMEOUT   = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [1:0]                          i_req_valid,
  output logic [1:0]                          o_req_ready,
  input  logic [1:0][1:0]                     i_req_op,
  input  logic [1:0]                          i_req_last,
  input  logic [1:0][WIDTH*UNIT_SIZE-1:0]     i_req_a,
  input  logic [1:0][WIDTH*UNIT_SIZE-1:0]     i_req_b,
  output logic [1:0]                          o_arr_op,
  output logic [WIDTH*UNIT_SIZE-1:0]          o_arr_a,
  output logic [WIDTH*UNIT_SIZE-1:0]          o_arr_b,
  output logic                                o_arr_run,
  output logic                                o_arr_rstn,
  input  logic                                i_arr_valid,
  input  logic [WIDTH*UNIT_SIZE-1:0]          i_arr_res,
  output logic                                o_rsp_valid,
  output logic                                o_rsp_id,
  output logic                                o_rsp_err,
  output logic [WIDTH*UNIT_SIZE-1:0]          o_rsp_data,
  output logic                                o_busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] OP_MAC = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

  state_t         state, state_d;
  logic           ptr;
  logic           gnt;
  logic [1:0]     op_q;
  logic [CW-1:0]  cnt;
  logic           last_ran;

  logic pick;
  logic accept;
  logic fin;
  logic timed_out;
  logic drain_done;

  assign pick       = (&i_req_valid) ? ptr : i_req_valid[1];
  assign accept     = (state == RUN) && i_req_valid[gnt];
  assign fin        = accept && i_req_last[gnt];
  assign timed_out  = (cnt == CW'(TIMEOUT - 1));
  // a final beat that never ran the array has nothing to wait for
  assign drain_done = !last_ran || i_arr_valid || timed_out;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (|i_req_valid)
          state_d = (i_req_op[pick] == OP_MAC) ? CLEAR : RUN;
      CLEAR: state_d = RUN;
      RUN:   if (fin) state_d = DRAIN;
      DRAIN: if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready      = '0;
    o_req_ready[gnt] = !i_rst && (state == RUN);
    o_arr_run        = !i_rst && (state == RUN) &&
                       i_req_valid[gnt] && (op_q != OP_RSV);
    o_arr_rstn       = !i_rst && (state != CLEAR);
    o_busy           = !i_rst && (state != IDLE);
    o_arr_op         = op_q;
    o_arr_a          = i_req_a[gnt];
    o_arr_b          = i_req_b[gnt];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      gnt         <= 1'b0;
      op_q        <= '0;
      cnt         <= '0;
      last_ran    <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_data  <= '0;
    end else begin
      state       <= state_d;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_id    <= gnt;
      if (state == IDLE && |i_req_valid) begin
        gnt  <= pick;
        op_q <= i_req_op[pick];
      end
      if (fin) begin
        last_ran <= (op_q != OP_RSV);
        cnt      <= '0;
      end
      if (state == DRAIN) cnt <= cnt + 1'b1;
      if (state == DRAIN && drain_done) ptr <= ~gnt;
      // MAC partial results during RUN are swallowed
      if (state == RUN) begin
        if (i_arr_valid && op_q != OP_MAC && op_q != OP_RSV) begin
          o_rsp_valid <= 1'b1;
          o_rsp_data  <= i_arr_res;
        end
      end else if (state == DRAIN) begin
        if (!last_ran) begin
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= 1'b1;
        end else if (i_arr_valid) begin
          o_rsp_valid <= 1'b1;
          o_rsp_data  <= i_arr_res;
        end else if (timed_out) begin
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_simd_job_sched.sv
// Directed bench for simd_job_sched with a behavioural simd_array.
// Covers ADD/SUB/MAC, reserved op, timeout, reset abort and fairness.
module tb_simd_job_sched;

  localparam int US = 32;
  localparam int W  = 5;
  localparam int TO = 4;
  localparam int DW = US * W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0][1:0]      req_op;
  logic [1:0]           req_last;
  logic [1:0][DW-1:0]   req_a;
  logic [1:0][DW-1:0]   req_b;
  logic [1:0]           arr_op;
  logic [DW-1:0]        arr_a;
  logic [DW-1:0]        arr_b;
  logic                 arr_run;
  logic                 arr_rstn;
  logic                 arr_valid;
  logic [DW-1:0]        arr_res;
  logic                 rsp_valid;
  logic                 rsp_id;
  logic                 rsp_err;
  logic [DW-1:0]        rsp_data;
  logic                 busy;

  always #5 clk = ~clk;

  simd_job_sched #(.UNIT_SIZE(US), .WIDTH(W), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_last(req_last),
    .i_req_a(req_a), .i_req_b(req_b),
    .o_arr_op(arr_op), .o_arr_a(arr_a), .o_arr_b(arr_b),
    .o_arr_run(arr_run), .o_arr_rstn(arr_rstn),
    .i_arr_valid(arr_valid), .i_arr_res(arr_res),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
    .o_rsp_err(rsp_err), .o_rsp_data(rsp_data),
    .o_busy(busy)
  );

  // behavioural array: one-cycle latency, MAC accumulator cleared by rstn
  logic [DW-1:0] acc, res_m, nxt_acc, nxt_res;
  logic          vld_m;
  logic          kill;

  always_comb begin
    nxt_acc = acc;
    nxt_res = '0;
    for (int i = 0; i < W; i++) begin
      unique case (arr_op)
        2'd0: nxt_res[i*US +: US] = arr_a[i*US +: US] + arr_b[i*US +: US];
        2'd1: nxt_res[i*US +: US] = arr_a[i*US +: US] - arr_b[i*US +: US];
        2'd2: begin
          nxt_acc[i*US +: US] = acc[i*US +: US] +
                                arr_a[i*US +: US] * arr_b[i*US +: US];
          nxt_res[i*US +: US] = nxt_acc[i*US +: US];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!arr_rstn) begin
      acc   <= '0;
      res_m <= '0;
      vld_m <= 1'b0;
    end else begin
      vld_m <= arr_run;
      if (arr_run) begin
        acc   <= nxt_acc;
        res_m <= nxt_res;
      end
    end
  end

  assign arr_valid = vld_m & ~kill;
  assign arr_res   = res_m;

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  logic          rq_id[$];
  logic          rq_err[$];
  logic [DW-1:0] rq_data[$];
  int            rq_cyc[$];
  int            clr_cnt = 0;
  int            run_cnt = 0;
  int            drain_cyc = 0;
  logic          in_drain = 1'b0;
  logic          drain_now;

  assign drain_now = busy && (req_ready == 2'b00) && arr_rstn;

  always @(negedge clk) begin
    if (rsp_valid) begin
      rq_id.push_back(rsp_id);
      rq_err.push_back(rsp_err);
      rq_data.push_back(rsp_data);
      rq_cyc.push_back(cyc);
    end
    if (!rst && !arr_rstn) clr_cnt <= clr_cnt + 1;
    if (arr_run) run_cnt <= run_cnt + 1;
    in_drain <= drain_now;
    if (drain_now && !in_drain) drain_cyc <= cyc;
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pk(input int v0, v1, v2, v3, v4);
    return {32'(v4), 32'(v3), 32'(v2), 32'(v1), 32'(v0)};
  endfunction

  task automatic beat(input int r, input logic [1:0] op,
                      input logic [DW-1:0] a, b, input logic last);
    logic ok;
    req_valid[r] = 1'b1;
    req_op[r]    = op;
    req_a[r]     = a;
    req_b[r]     = b;
    req_last[r]  = last;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[r]) ok = 1'b1;
    end
    chk("handshake", DW'(ok), DW'(1));
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int n, input bit exact);
    for (int k = 0; k < 40 && rq_id.size() < n; k++) @(posedge clk);
    if (exact) repeat (6) @(posedge clk);
    if (exact || rq_id.size() < n)
      chk(tag, DW'(rq_id.size()), DW'(n));
  endtask

  int base;
  int c0;

  initial begin
    rst       = 1'b1;
    kill      = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_last  = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", DW'(req_ready), DW'(0));
    chk("rst_run", DW'(arr_run), DW'(0));
    chk("rst_rstn", DW'(arr_rstn), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_rsp", DW'(rsp_valid), DW'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_rstn", DW'(arr_rstn), DW'(1));
    chk("idle_busy", DW'(busy), DW'(0));

    base = rq_id.size();
    c0   = clr_cnt;
    beat(0, 2'd0, pk(0, 1, 2, 3, 4), pk(0, 1, 2, 3, 4), 1'b1);
    wait_rsp("add_cnt", base + 1, 1'b1);
    chk("add_id", DW'(rq_id[base]), DW'(0));
    chk("add_err", DW'(rq_err[base]), DW'(0));
    chk("add_data", rq_data[base], pk(0, 2, 4, 6, 8));
    chk("add_noclr", DW'(clr_cnt - c0), DW'(0));

    base = rq_id.size();
    beat(1, 2'd1, pk(6, 9, 12, 15, 18), pk(0, 4, 8, 12, 16), 1'b0);
    beat(1, 2'd1, pk(1, 1, 1, 1, 1), pk(1, 1, 1, 1, 1), 1'b1);
    wait_rsp("sub_cnt", base + 2, 1'b1);
    chk("sub_id", DW'(rq_id[base]), DW'(1));
    chk("sub_d0", rq_data[base], pk(6, 5, 4, 3, 2));
    chk("sub_d1", rq_data[base+1], pk(0, 0, 0, 0, 0));
    chk("sub_err", DW'(rq_err[base+1]), DW'(0));

    base = rq_id.size();
    c0   = clr_cnt;
    beat(0, 2'd2, pk(4, 6, 8, 10, 12), pk(2, 3, 4, 5, 14), 1'b0);
    beat(0, 2'd2, pk(2, 4, 6, 8, 91), pk(3, 4, 5, 6, -1), 1'b1);
    wait_rsp("mac_cnt", base + 1, 1'b1);
    chk("mac_data", rq_data[base], pk(14, 34, 62, 98, 77));
    chk("mac_err", DW'(rq_err[base]), DW'(0));
    chk("mac_clr", DW'(clr_cnt - c0), DW'(1));

    base = rq_id.size();
    c0   = run_cnt;
    beat(1, 2'd3, pk(5, 5, 5, 5, 5), pk(7, 7, 7, 7, 7), 1'b0);
    beat(1, 2'd3, pk(5, 5, 5, 5, 5), pk(7, 7, 7, 7, 7), 1'b1);
    wait_rsp("rsv_cnt", base + 1, 1'b1);
    chk("rsv_id", DW'(rq_id[base]), DW'(1));
    chk("rsv_err", DW'(rq_err[base]), DW'(1));
    chk("rsv_data", rq_data[base], '0);
    chk("rsv_norun", DW'(run_cnt - c0), DW'(0));

    base = rq_id.size();
    kill = 1'b1;
    beat(0, 2'd0, pk(1, 1, 1, 1, 1), pk(1, 1, 1, 1, 1), 1'b1);
    wait_rsp("to_cnt", base + 1, 1'b1);
    kill = 1'b0;
    chk("to_err", DW'(rq_err[base]), DW'(1));
    chk("to_data", rq_data[base], '0);
    chk("to_lat", DW'(rq_cyc[base] - drain_cyc), DW'(TO));

    base = rq_id.size();
    beat(0, 2'd2, pk(1, 2, 3, 4, 5), pk(1, 1, 1, 1, 1), 1'b0);
    beat(0, 2'd2, pk(1, 2, 3, 4, 5), pk(1, 1, 1, 1, 1), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("ab_rstn0", DW'(arr_rstn), DW'(0));
    chk("ab_busy", DW'(busy), DW'(0));
    chk("ab_ready", DW'(req_ready), DW'(0));
    @(negedge clk);
    chk("ab_rstn1", DW'(arr_rstn), DW'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ab_idle", DW'(busy), DW'(0));
    wait_rsp("ab_norsp", base, 1'b1);

    base = rq_id.size();
    req_op    = '0;
    req_last  = 2'b11;
    req_a[0]  = pk(1, 1, 1, 1, 1);
    req_b[0]  = pk(1, 1, 1, 1, 1);
    req_a[1]  = pk(10, 10, 10, 10, 10);
    req_b[1]  = '0;
    req_valid = 2'b11;
    wait_rsp("rr_cnt", base + 4, 1'b0);
    req_valid = 2'b00;
    if (rq_id.size() >= base + 4) begin
      chk("rr_id0", DW'(rq_id[base]), DW'(0));
      chk("rr_id1", DW'(rq_id[base+1]), DW'(1));
      chk("rr_id2", DW'(rq_id[base+2]), DW'(0));
      chk("rr_id3", DW'(rq_id[base+3]), DW'(1));
      chk("rr_d0", rq_data[base], pk(2, 2, 2, 2, 2));
      chk("rr_d1", rq_data[base+1], pk(10, 10, 10, 10, 10));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/simd_job_sched.md
Name: simd_job_sched

Overview:
- Round-robin scheduler that shares one simd_array (WIDTH lanes × UNIT_SIZE bits; ops ADD/SUB/MAC; 1-cycle run→valid latency) between two requesters.
- Grants the array per job, where a job is a beat stream ending with `last`.
- Issues the array accumulator-clear pulse before MAC jobs.
- Filters array results into per-requester responses, with a watchdog on missing array results.

Parameters:
- UNIT_SIZE, 32, lane width in bits
- WIDTH, 5, number of lanes
- TIMEOUT, 4, cycles DRAIN waits for i_arr_valid before reporting an error (≥2)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_req_valid  in  2  beat valid, one bit per requester r
- o_req_ready  out  2  beat accepted on valid&ready at rising edge
- i_req_op  in  2×2  op of requester r: 0 ADD, 1 SUB, 2 MAC, 3 reserved
- i_req_last  in  2  final beat of job
- i_req_a  in  2×WIDTH×UNIT_SIZE  operand A, flattened, lane i at [i*UNIT_SIZE +: UNIT_SIZE]
- i_req_b  in  2×WIDTH×UNIT_SIZE  operand B, same layout
- o_arr_op  out  2  array opcode
- o_arr_a  out  WIDTH×UNIT_SIZE  array operand A
- o_arr_b  out  WIDTH×UNIT_SIZE  array operand B
- o_arr_run  out  1  array run strobe
- o_arr_rstn  out  1  array reset, active-low; used as MAC clear
- i_arr_valid  in  1  array result valid
- i_arr_res  in  WIDTH×UNIT_SIZE  array result
- o_rsp_valid  out  1  response valid, one-cycle pulse, no backpressure
- o_rsp_id  out  1  requester owning the response
- o_rsp_err  out  1  reserved op or timeout
- o_rsp_data  out  WIDTH×UNIT_SIZE  result lanes
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (sync, while i_rst=1):
  - state=IDLE, priority pointer=0.
  - o_req_ready=0, o_arr_run=0, o_arr_rstn=0.
  - o_rsp_* = 0 and o_busy=0.
  - Any job in flight is dropped silently; no response is issued.
- Outside reset, o_arr_rstn=1 except in CLEAR.
- States: IDLE, CLEAR, RUN, DRAIN.
- IDLE:
  - Pick a requester with i_req_valid; if both valid, pick the pointer's requester.
  - Latch grant id and op = i_req_op[grant] at the edge.
  - Next state: CLEAR if op=MAC, else RUN.
  - No beat is accepted in IDLE.
- CLEAR: o_arr_rstn=0 for exactly one cycle, then RUN.
- RUN:
  - o_req_ready[grant]=1; the other requester's ready stays 0.
  - Combinational passthrough: o_arr_a/b = granted operands, o_arr_op = latched op.
  - o_arr_run = i_req_valid[grant], forced to 0 when op=3.
  - Per-beat i_req_op is ignored after grant.
  - Accepted beat with last=1 → DRAIN; record whether that final beat ran the array.
- DRAIN:
  - o_req_ready=0, o_arr_run=0.
  - Watchdog counter starts at 0 on entry.
  - Exit on i_arr_valid, or on counter reaching TIMEOUT-1 with no i_arr_valid.
  - Op=3 exits DRAIN on its first cycle.
  - On exit: toggle pointer to the non-granted requester; next state IDLE.
- Responses (registered; beat accepted at edge t → array valid in cycle t+1 → o_rsp_valid in cycle t+2):
  - ADD/SUB: each i_arr_valid during RUN/DRAIN → one response with o_rsp_data=i_arr_res, err=0.
  - MAC: i_arr_valid during RUN is suppressed. The DRAIN i_arr_valid → single response with the accumulated lanes, err=0.
  - Op=3: beats are consumed without running the array; on last → one response, err=1, data=0.
  - Timeout: response err=1, data=0.
- o_rsp_id = latched grant.
- Arithmetic is done in the array; the scheduler never modifies data width or lanes.
- Boundaries:
  - Single-beat job (valid+last on first RUN cycle) is legal.
  - A requester holding valid after its job is re-granted only if the other requester is idle or the pointer favours it.
  - i_rst during RUN/DRAIN → IDLE next cycle, o_arr_rstn low for the reset duration.

Test Plan:
- ADD, requester 0, one beat: a lanes=0..4, b=0..4, last=1 → o_rsp_valid once, id=0, data lanes {0,2,4,6,8}, err=0; o_arr_rstn never low.
- SUB, requester 1, two beats: a lanes=3(i+2), b=4i, then a=b=1 with last → two responses; first data {6,5,4,3,2}, second all 0.
- MAC, requester 0, two beats: beat 1 a={4,6,8,10,12}, b={2,3,4,5,14}; beat 2 a={2,4,6,8,91}, b={3,4,5,6,-1} with last → one CLEAR cycle before RUN; exactly one response, data {14,34,62,98,77}.
- Both requesters valid continuously with single-beat ADD jobs → grants alternate 0,1,0,1; o_rsp_id sequence matches.
- Op=3 job from requester 1 → beats accepted, o_arr_run stays 0, one response err=1 data=0. Separately, hold i_arr_valid=0 on ADD → response err=1 exactly TIMEOUT cycles after DRAIN entry.
- Assert i_rst during a three-beat MAC after beat 2 → no response; o_busy=0 and state=IDLE next cycle; o_arr_rstn=0 while reset is held; the next job is granted to requester 0.
